// File: rtl/if_id_fetch_stage.sv
// Fetch stage: PC register, single-outstanding imem request and the IF/ID register; 2 cycles/instr with 1-cycle memory.
// Stalls park a returned word in a hold buffer (no loss); flushes redirect the PC and drain any owed response.
module if_id_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pcwrite,
    input  logic        ifid_write,
    input  logic        flush,
    input  logic [31:0] branch_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_valid,
    output logic [31:0] ifid_pc,
    output logic [31:0] ifid_instr,
    output logic        ifid_valid
);

    typedef enum logic [1:0] {FETCH, WAIT, HOLD, DRAIN} state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_live;
    logic [31:0] r_pc;
    logic [31:0] r_hold_dat;
    logic [31:0] r_ifid_pc;
    logic [31:0] r_ifid_instr;
    logic        r_ifid_valid;

    logic        w_req;
    logic        w_go;
    logic        w_load_mem;
    logic        w_load_hold;
    logic        w_bubble;
    logic        w_capture;

    // r_live keeps the request low while reset is held and for the first cycle after release
    assign w_req = (r_state == FETCH) && r_live;
    assign w_go  = ifid_write && pcwrite;

    always_comb begin
        w_state_nxt = r_state;
        w_load_mem  = 1'b0;
        w_load_hold = 1'b0;
        w_bubble    = 1'b0;
        w_capture   = 1'b0;
        if (flush) begin
            case (r_state)
                FETCH:   w_state_nxt = w_req ? DRAIN : FETCH;
                WAIT:    w_state_nxt = imem_valid ? FETCH : DRAIN;
                HOLD:    w_state_nxt = FETCH;
                DRAIN:   w_state_nxt = imem_valid ? FETCH : DRAIN;
                default: w_state_nxt = FETCH;
            endcase
        end else begin
            case (r_state)
                FETCH: begin
                    w_bubble = ifid_write;
                    if (w_req) begin
                        w_state_nxt = WAIT;
                    end
                end
                WAIT: begin
                    if (imem_valid) begin
                        if (w_go) begin
                            w_load_mem  = 1'b1;
                            w_state_nxt = FETCH;
                        end else begin
                            w_capture   = 1'b1;
                            w_state_nxt = HOLD;
                        end
                    end else begin
                        w_bubble = ifid_write;
                    end
                end
                HOLD: begin
                    if (w_go) begin
                        w_load_hold = 1'b1;
                        w_state_nxt = FETCH;
                    end
                end
                DRAIN: begin
                    if (imem_valid) begin
                        w_state_nxt = FETCH;
                    end
                end
                default: w_state_nxt = FETCH;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= FETCH;
            r_live  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_live  <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc         <= RESET_PC;
            r_hold_dat   <= 32'h0;
            r_ifid_pc    <= 32'h0;
            r_ifid_instr <= NOP_INSTR;
            r_ifid_valid <= 1'b0;
        end else if (flush) begin
            r_pc         <= branch_target;
            r_hold_dat   <= 32'h0;
            r_ifid_pc    <= 32'h0;
            r_ifid_instr <= NOP_INSTR;
            r_ifid_valid <= 1'b0;
        end else begin
            if (w_load_mem || w_load_hold) begin
                r_ifid_pc    <= r_pc;
                r_ifid_instr <= w_load_mem ? imem_rdata : r_hold_dat;
                r_ifid_valid <= 1'b1;
                r_pc         <= r_pc + 32'd4;
            end else if (w_bubble) begin
                r_ifid_pc    <= 32'h0;
                r_ifid_instr <= NOP_INSTR;
                r_ifid_valid <= 1'b0;
            end
            if (w_capture) begin
                r_hold_dat <= imem_rdata;
            end
        end
    end

    assign imem_req   = w_req;
    assign imem_addr  = r_pc;
    assign ifid_pc    = r_ifid_pc;
    assign ifid_instr = r_ifid_instr;
    assign ifid_valid = r_ifid_valid;

endmodule

// File: tb/tb_if_id_fetch_stage.sv
// Directed bench for if_id_fetch_stage: latency-programmable memory responder, transaction-level model
// compared every cycle, plus hand-computed literal expectations for each scenario.
module tb_if_id_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst_n;
    logic        pcwrite;
    logic        ifid_write;
    logic        flush;
    logic [31:0] branch_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_valid;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_instr;
    logic        ifid_valid;

    int n_pass = 0;
    int n_tot  = 0;

    if_id_fetch_stage dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pcwrite       (pcwrite),
        .ifid_write    (ifid_write),
        .flush         (flush),
        .branch_target (branch_target),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .imem_valid    (imem_valid),
        .ifid_pc       (ifid_pc),
        .ifid_instr    (ifid_instr),
        .ifid_valid    (ifid_valid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at t=%0t", nm, act, exp, $time);
    endtask

    // Memory responder: answers each request after 'lat' cycles
    int          lat = 1;
    bit          force_en = 1'b0;
    logic [31:0] force_dat = 32'h0;
    bit          pend = 1'b0;
    int          cnt = 0;
    logic [31:0] paddr = 32'h0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0:   return 32'h0050_0093;
            32'h4:   return 32'h0010_0113;
            32'h8:   return 32'hDEAD_BEEF;
            default: return {a[15:0], 16'hC0DE};
        endcase
    endfunction

    initial begin
        imem_valid = 1'b0;
        imem_rdata = 32'h0;
    end

    always @(negedge clk) begin
        imem_valid = 1'b0;
        if (!rst_n) begin
            pend = 1'b0;
        end else begin
            if (pend) begin
                if (cnt <= 1) begin
                    imem_valid = 1'b1;
                    imem_rdata = force_en ? force_dat : mem_word(paddr);
                    pend = 1'b0;
                end else begin
                    cnt--;
                end
            end
            if (imem_req) begin
                pend  = 1'b1;
                cnt   = lat;
                paddr = imem_addr;
            end
        end
    end

    // Transaction-level model: tracks an owed response, whether it is to be dropped, and a parked word
    logic [31:0] m_pc = 32'h0, m_ipc = 32'h0, m_ins = NOP, m_hdat = 32'h0;
    logic        m_vld = 1'b0, m_owe = 1'b0, m_disc = 1'b0, m_held = 1'b0, m_started = 1'b0;
    logic        m_req;
    assign m_req = m_started && !m_owe && !m_held;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pc <= 32'h0; m_ipc <= 32'h0; m_ins <= NOP; m_vld <= 1'b0; m_hdat <= 32'h0;
            m_owe <= 1'b0; m_disc <= 1'b0; m_held <= 1'b0; m_started <= 1'b0;
        end else begin
            m_started <= 1'b1;
            if (flush) begin
                m_pc <= branch_target; m_ipc <= 32'h0; m_ins <= NOP; m_vld <= 1'b0; m_held <= 1'b0;
                if (m_req) begin
                    m_owe <= 1'b1; m_disc <= 1'b1;
                end else if (m_owe && imem_valid) begin
                    m_owe <= 1'b0;
                end else if (m_owe) begin
                    m_disc <= 1'b1;
                end
            end else if (m_owe && !m_disc) begin
                if (imem_valid) begin
                    m_owe <= 1'b0;
                    if (ifid_write && pcwrite) begin
                        m_ipc <= m_pc; m_ins <= imem_rdata; m_vld <= 1'b1; m_pc <= m_pc + 32'd4;
                    end else begin
                        m_held <= 1'b1; m_hdat <= imem_rdata;
                    end
                end else if (ifid_write) begin
                    m_ipc <= 32'h0; m_ins <= NOP; m_vld <= 1'b0;
                end
            end else if (m_owe) begin
                if (imem_valid) m_owe <= 1'b0;
            end else if (m_held) begin
                if (ifid_write && pcwrite) begin
                    m_ipc <= m_pc; m_ins <= m_hdat; m_vld <= 1'b1; m_pc <= m_pc + 32'd4; m_held <= 1'b0;
                end
            end else begin
                if (ifid_write) begin
                    m_ipc <= 32'h0; m_ins <= NOP; m_vld <= 1'b0;
                end
                if (m_req) begin
                    m_owe <= 1'b1; m_disc <= 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("cyc_req",   32'(imem_req),   32'(m_req));
        chk("cyc_addr",  imem_addr,       m_pc);
        chk("cyc_ifpc",  ifid_pc,         m_ipc);
        chk("cyc_instr", ifid_instr,      m_ins);
        chk("cyc_vld",   32'(ifid_valid), 32'(m_vld));
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_req();
        bit seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (imem_req) seen = 1'b1;
        end
        chk("req_seen", 32'(seen), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; pcwrite = 1'b1; ifid_write = 1'b1; flush = 1'b0; branch_target = 32'h0;
        tick(2);
        chk("rst_req",   32'(imem_req),   32'd0);
        chk("rst_instr", ifid_instr,      NOP);
        chk("rst_vld",   32'(ifid_valid), 32'd0);
        chk("rst_ifpc",  ifid_pc,         32'h0);
        chk("rst_addr",  imem_addr,       32'h0);
        rst_n = 1'b1;

        // First two fetches with 1-cycle memory
        wait_req();
        chk("req0_addr", imem_addr, 32'h0);
        tick(2);
        chk("i0_instr", ifid_instr,      32'h0050_0093);
        chk("i0_pc",    ifid_pc,         32'h0);
        chk("i0_vld",   32'(ifid_valid), 32'd1);
        chk("req1",     32'(imem_req),   32'd1);
        chk("req1_addr", imem_addr,      32'h4);
        tick(2);
        chk("i1_instr", ifid_instr, 32'h0010_0113);
        chk("i1_pc",    ifid_pc,    32'h4);
        chk("req2_addr", imem_addr, 32'h8);

        // Stall for 3 cycles starting in WAIT while DEADBEEF returns
        tick(1);
        ifid_write = 1'b0; pcwrite = 1'b0;
        tick(1);
        chk("stall_req_a", 32'(imem_req), 32'd0);
        chk("stall_frz_a", ifid_instr,     NOP);
        tick(1);
        chk("stall_req_b", 32'(imem_req), 32'd0);
        tick(1);
        chk("stall_req_c", 32'(imem_req), 32'd0);
        chk("stall_frz_c", ifid_instr,     NOP);
        ifid_write = 1'b1; pcwrite = 1'b1;
        lat = 3; force_en = 1'b1; force_dat = 32'h1111_1111;
        tick(1);
        chk("unstall_instr", ifid_instr, 32'hDEAD_BEEF);
        chk("unstall_pc",    ifid_pc,    32'h8);
        chk("unstall_addr",  imem_addr,  32'hC);

        // Flush in WAIT; response lands two cycles later and must be dropped
        tick(1);
        flush = 1'b1; branch_target = 32'h100;
        tick(1);
        flush = 1'b0; lat = 1;
        chk("drain_vld",  32'(ifid_valid), 32'd0);
        chk("drain_req",  32'(imem_req),   32'd0);
        tick(1);
        chk("drain_vld2", 32'(ifid_valid), 32'd0);
        tick(1);
        force_en = 1'b0;
        chk("redir_req",   32'(imem_req), 32'd1);
        chk("redir_addr",  imem_addr,     32'h100);
        chk("redir_instr", ifid_instr,    NOP);

        // Flush coinciding with the response: no drain
        tick(1);
        flush = 1'b1; branch_target = 32'h200;
        tick(1);
        flush = 1'b0;
        chk("fv_req",  32'(imem_req),   32'd1);
        chk("fv_addr", imem_addr,       32'h200);
        chk("fv_vld",  32'(ifid_valid), 32'd0);
        tick(2);
        chk("fv_instr", ifid_instr, 32'h0200_C0DE);
        chk("fv_pc",    ifid_pc,    32'h200);

        // Flush together with a stall while IF/ID holds a real instruction
        flush = 1'b1; ifid_write = 1'b0; pcwrite = 1'b0; branch_target = 32'h300;
        tick(1);
        flush = 1'b0; ifid_write = 1'b1; pcwrite = 1'b1;
        chk("fs_instr", ifid_instr,      NOP);
        chk("fs_vld",   32'(ifid_valid), 32'd0);
        chk("fs_ifpc",  ifid_pc,         32'h0);
        chk("fs_addr",  imem_addr,       32'h300);
        tick(1);
        chk("fs_req", 32'(imem_req), 32'd1);
        tick(2);
        chk("fs_next", ifid_instr, 32'h0300_C0DE);

        // PC wrap at the top of the address space
        flush = 1'b1; branch_target = 32'hFFFF_FFFC;
        tick(1);
        flush = 1'b0;
        tick(1);
        chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        tick(1);
        lat = 2;
        tick(1);
        chk("wrap_ifpc",  ifid_pc,       32'hFFFF_FFFC);
        chk("wrap_instr", ifid_instr,    32'hFFFC_C0DE);
        chk("wrap_pc",    imem_addr,     32'h0);
        chk("wrap_req",   32'(imem_req), 32'd1);
        ifid_write = 1'b0;

        // Async reset in the middle of WAIT
        tick(1);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_vld",   32'(ifid_valid), 32'd0);
        chk("arst_instr", ifid_instr,      NOP);
        chk("arst_ifpc",  ifid_pc,         32'h0);
        chk("arst_req",   32'(imem_req),   32'd0);
        tick(2);
        ifid_write = 1'b1; lat = 1; rst_n = 1'b1;
        wait_req();
        chk("post_addr", imem_addr, 32'h0);
        tick(2);
        chk("post_instr", ifid_instr, 32'h0050_0093);
        tick(2);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/if_id_fetch_stage.md
Name: if_id_fetch_stage

Overview:
- Fetch-side consumer of the load-use stall signals (pcwrite, ifid_write) and the branch redirect.
- Owns the PC register, the instruction-memory request handshake and the IF/ID pipeline register for the RV32I core.
- Sits between the instruction memory and the ID stage.
- Guarantees stalls freeze the fetched instruction without loss, and redirects discard in-flight fetches.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded at reset.
- NOP_INSTR, 32'h0000_0013, bubble encoding (addi x0,x0,0) placed in IF/ID when empty or flushed.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- pcwrite  input  1  1 = PC may advance; 0 = hold PC (load-use stall).
- ifid_write  input  1  1 = IF/ID may load; 0 = hold IF/ID contents.
- flush  input  1  branch/jump taken in ID; redirect fetch.
- branch_target  input  32  redirect PC, sampled when flush=1.
- imem_req  output  1  one-cycle fetch request pulse.
- imem_addr  output  32  fetch address; equals pc.
- imem_rdata  input  32  fetched instruction, valid when imem_valid=1.
- imem_valid  input  1  response strobe; arrives 1 or more cycles after imem_req, one response per request.
- ifid_pc  output  32  PC of the instruction in IF/ID.
- ifid_instr  output  32  instruction in IF/ID.
- ifid_valid  output  1  IF/ID holds a real instruction.

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_PC; ifid_pc=0; ifid_instr=NOP_INSTR; ifid_valid=0; imem_req=0; hold buffer cleared; state=FETCH.
- States: FETCH, WAIT, HOLD, DRAIN.
- FETCH:
  - imem_req=1 for this cycle only, imem_addr=pc.
  - Next state WAIT.
  - If ifid_write=1, IF/ID loads a bubble (NOP_INSTR, ifid_valid=0).
- WAIT, imem_valid=1, ifid_write=1, pcwrite=1:
  - IF/ID <= {pc, imem_rdata}, ifid_valid=1; pc <= pc+4 (mod 2^32, wraps at 32'hFFFF_FFFC).
  - Next state FETCH.
- WAIT, imem_valid=1, ifid_write=0 or pcwrite=0:
  - imem_rdata captured into the hold buffer; IF/ID and pc unchanged.
  - Next state HOLD.
- WAIT, imem_valid=0:
  - If ifid_write=1, IF/ID loads a bubble; otherwise IF/ID holds.
- HOLD:
  - No request issued.
  - When ifid_write=1 and pcwrite=1: IF/ID <= {pc, buffer}, ifid_valid=1; pc <= pc+4; next FETCH.
  - Otherwise remain in HOLD.
- flush=1, highest priority over stall and response, any state:
  - pc <= branch_target; IF/ID <= NOP_INSTR, ifid_valid=0, ifid_pc=0; hold buffer invalidated.
  - From WAIT without imem_valid in the same cycle: next DRAIN.
  - From WAIT with imem_valid in the same cycle: the response is discarded; next FETCH.
  - From FETCH: the request pulse issued this cycle still occurs, so next DRAIN.
  - From HOLD or DRAIN: next FETCH, or stay DRAIN if a response is still owed.
- DRAIN:
  - No request issued; the next imem_valid is discarded; then FETCH.
  - A further flush in DRAIN updates pc and stays in DRAIN.
- At most one outstanding request at any time; imem_req never asserted outside FETCH.
- Latency:
  - Minimum 2 cycles per instruction with single-cycle memory (FETCH, then WAIT with imem_valid).
  - A flush costs at least 2 bubble cycles.
- ifid_pc/ifid_instr change only on load, flush or reset.
- Reset mid-fetch abandons the outstanding request. Memory-side handling of that orphan response is out of scope; a stray imem_valid while in FETCH is ignored.

Test Plan:
- Reset release, 1-cycle memory returning 32'h00500093 at 0x0 and 32'h00100113 at 0x4.
  - Required: imem_req pulses at addr 0x0 then 0x4.
  - Required: ifid_instr=32'h00500093 / ifid_pc=0x0, ifid_valid=1, two cycles after first req.
- Stall: ifid_write=pcwrite=0 asserted for 3 cycles while in WAIT, imem_valid=1 with 32'hDEADBEEF.
  - Required: IF/ID frozen, no imem_req during stall.
  - Required: 32'hDEADBEEF enters IF/ID on the first cycle stall drops; pc then advances by 4.
- flush with branch_target=0x100 while WAIT, response 32'h11111111 arriving 2 cycles later.
  - Required: response discarded, ifid_valid=0.
  - Required: next imem_req has addr 0x100.
- flush and imem_valid in the same cycle.
  - Required: response dropped, next cycle FETCH at branch_target, no DRAIN.
- flush and ifid_write=0 in the same cycle.
  - Required: flush wins, IF/ID=NOP_INSTR, pc=branch_target.
- pc=32'hFFFF_FFFC fetch completes.
  - Required: pc wraps to 0x0; async reset asserted mid-WAIT gives immediate reset values without a clock edge.
